// File: rtl/fifo_stream_reader.sv
// FIFO read-port to valid/ready stream adapter with a 2-entry output buffer.
// Optional handshake counter: define FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic                  inflight;
  logic                  land;
  logic                  pop;
  logic                  valid_q;
  logic [2:0]            occ_next;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  assign land = inflight;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= EMPTY;
      valid_q  <= 1'b0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      valid_q  <= (state_next != EMPTY);
      inflight <= fifo_read_en;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: begin
        if (land) state_next = ONE;
      end
      ONE: begin
        if (land && !pop)      state_next = TWO;
        else if (!land && pop) state_next = EMPTY;
      end
      TWO: begin
        if (pop && !land) state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Pop lookahead lets a read issue in the same cycle a slot frees up.
  always_comb begin
    m_valid      = valid_q;
    m_data       = head;
    pop          = valid_q & m_ready;
    occ_next     = {1'b0, state} + {2'b00, inflight} - {2'b00, pop};
    fifo_read_en = reset_n & ~fifo_empty & (occ_next <= 3'd1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (land) head <= fifo_data_out;
        end
        ONE: begin
          if (land && pop) head <= fifo_data_out;
          else if (land)   tail <= fifo_data_out;
        end
        TWO: begin
          if (pop) begin
            head <= tail;
            if (land) tail <= fifo_data_out;
          end
        end
        default: begin
          head <= head;
        end
      endcase
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n)
      xfer_count <= '0;
    else if (pop && (xfer_count != {CNT_WIDTH{1'b1}}))
      xfer_count <= xfer_count + 1'b1;
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule
